// File: rtl/cs161_mc_control_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control unit.
// The master modport is the controller; the slave modport is the datapath side.
interface cs161_mc_control_if;
    logic [5:0] instr_op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  instr_op, funct, mem_ready,
        output reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write,
               pc_write, ir_write, iord, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal_op, state
    );

    modport slave (
        output instr_op, funct, mem_ready,
        input  reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write,
               pc_write, ir_write, iord, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal_op, state
    );
endinterface

// File: rtl/cs161_mc_control.sv
// Multicycle MIPS control FSM: Moore control decode per state, with the FETCH
// handshake strobes, R_EX alu_op and DECODE illegal_op as the input-dependent outputs.
module cs161_mc_control (
    input logic               clk,
    input logic               rst,
    cs161_mc_control_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EX     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0] cur, nxt;
    logic       op_ok, fn_ok, bad_instr;
    logic [3:0] r_alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        op_ok = (bus.instr_op == OP_R)    || (bus.instr_op == OP_LW)   ||
                (bus.instr_op == OP_SW)   || (bus.instr_op == OP_BEQ)  ||
                (bus.instr_op == OP_ADDI) || (bus.instr_op == OP_J);
        fn_ok = 1'b1;
        case (bus.funct)
            6'b100000: r_alu_op = 4'b0010;
            6'b100010: r_alu_op = 4'b0110;
            6'b100100: r_alu_op = 4'b0000;
            6'b100101: r_alu_op = 4'b0001;
            6'b100111: r_alu_op = 4'b1100;
            6'b101010: r_alu_op = 4'b0111;
            default: begin
                r_alu_op = 4'b0000;
                fn_ok    = 1'b0;
            end
        endcase
        bad_instr = !op_ok || (bus.instr_op == OP_R && !fn_ok);
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!bad_instr) begin
                    case (bus.instr_op)
                        OP_LW, OP_SW: nxt = S_MEM_ADDR;
                        OP_R:         nxt = S_R_EX;
                        OP_BEQ:       nxt = S_BEQ;
                        OP_ADDI:      nxt = S_ADDI_EX;
                        OP_J:         nxt = S_JUMP;
                        default:      nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                if (bus.instr_op == OP_LW)      nxt = S_MEM_RD;
                else if (bus.instr_op == OP_SW) nxt = S_MEM_WR;
            end
            S_MEM_RD:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  nxt = bus.mem_ready ? S_FETCH  : S_MEM_WR;
            S_R_EX:    nxt = S_R_WB;
            S_ADDI_EX: nxt = S_ADDI_WB;
            default:   nxt = S_FETCH;
        endcase
    end

    logic       reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write;
    logic       pc_write, ir_write, iord, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;

    // Outputs are gated by rst so that FETCH's mem_read is also silent in reset.
    always_comb begin
        reg_dst    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        alu_op     = 4'b0000;
        illegal_op = 1'b0;
        if (rst) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 4'b0010;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    alu_op     = 4'b0010;
                    illegal_op = bad_instr;
                end
                S_MEM_ADDR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 4'b0010;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_alu_op;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 4'b0110;
                    branch    = 1'b1;
                    pc_source = 2'b01;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.reg_dst    = reg_dst;
    assign bus.branch     = branch;
    assign bus.mem_read   = mem_read;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.iord       = iord;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_source  = pc_source;
    assign bus.alu_op     = alu_op;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = cur;
endmodule
